// File: rtl/sram_uart_fifo.sv
// 16550-subset UART front end on an SRAM-style MMIO port with TX/RX byte FIFOs.
// Optional interrupt logic (IER register, irq output) is built only when SRAM_UART_IRQ_EN is defined.
module sram_uart_fifo #(
  parameter logic [63:0] BASE_ADDR = 64'h6000_0000,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic [63:0] addra,
  input  logic [63:0] dina,
  output logic [63:0] douta,
  input  logic        ena,
  input  logic [7:0]  wea,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        irq
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_PW = RX_AW + 1;

  localparam logic [TX_PW-1:0] TX_FULL_XOR = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_PW-1:0] RX_FULL_XOR = {1'b1, {RX_AW{1'b0}}};

  localparam logic [2:0] OFF_RBR = 3'd0;
  localparam logic [2:0] OFF_IER = 3'd1;
  localparam logic [2:0] OFF_LSR = 3'd5;

  // Address bits above the register select and unused data lanes are decoded upstream.
  logic unused_ok;
  assign unused_ok = &{1'b0, addra[63:3], dina[63:8], BASE_ADDR};

  // ---------------------------------------------------------------------------
  // Bus access decode
  // ---------------------------------------------------------------------------
  logic bus_rd;
  logic rbr_rd;
  logic lsr_rd;
  logic thr_wr;

  assign bus_rd = ena & (wea == 8'h00);
  assign rbr_rd = bus_rd & (addra[2:0] == OFF_RBR);
  assign lsr_rd = bus_rd & (addra[2:0] == OFF_LSR);
  assign thr_wr = ena & wea[0];

  // ---------------------------------------------------------------------------
  // TX FIFO and output stage
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_wptr;
  logic [TX_PW-1:0] tx_rptr;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_stage_free;

  assign tx_empty      = (tx_wptr == tx_rptr);
  assign tx_full       = ((tx_wptr ^ tx_rptr) == TX_FULL_XOR);
  assign tx_push       = thr_wr & ~tx_full;
  assign tx_stage_free = ~tx_valid | tx_ready;
  assign tx_pop        = tx_stage_free & ~tx_empty;

  // NOTE: FIFO storage has no reset; the reset pointers already mark every entry invalid.
  always_ff @(posedge clka) begin
    if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= dina[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_stage_free) begin
        tx_valid <= ~tx_empty;
        if (!tx_empty) tx_data <= tx_mem[tx_rptr[TX_AW-1:0]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO and overrun flag
  // ---------------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_wptr;
  logic [RX_PW-1:0] rx_rptr;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic             oe;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = ((rx_wptr ^ rx_rptr) == RX_FULL_XOR);
  assign rx_push  = rx_ready & ~rx_full;
  assign rx_pop   = rbr_rd & ~rx_empty;

  always_ff @(posedge clka) begin
    if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clka) begin
    if (!rstn) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      oe      <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      // A new overrun in the same cycle as an LSR read stays visible for the next read.
      if (rx_ready && rx_full) oe <= 1'b1;
      else if (lsr_rd)         oe <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt enable and interrupt line
  // ---------------------------------------------------------------------------
  logic [1:0] ier;

`ifdef SRAM_UART_IRQ_EN
  logic ier_wr;
  assign ier_wr = ena & wea[1];

  always_ff @(posedge clka) begin
    if (!rstn) begin
      ier <= 2'b00;
      irq <= 1'b0;
    end else begin
      if (ier_wr) ier <= dina[9:8];
      irq <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty);
    end
  end
`else
  assign ier = 2'b00;
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read data: every lane of the addressed word, registered
  // ---------------------------------------------------------------------------
  logic [7:0]  rbr_byte;
  logic [7:0]  lsr_byte;
  logic [63:0] read_word;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rbr_byte = 8'h00;
    if (!rx_empty) rbr_byte = rx_mem[rx_rptr[RX_AW-1:0]];
  end

  assign lsr_byte  = {1'b0, tx_empty & ~tx_valid, tx_empty, 3'b000, oe, ~rx_empty};
  assign read_word = {16'h0000, lsr_byte, 24'h000000, 6'b000000, ier, rbr_byte};

  always_ff @(posedge clka) begin
    if (!rstn)    douta <= 64'h0;
    else if (ena) douta <= read_word;
  end

endmodule

// File: tb/tb_sram_uart_fifo.sv
// Directed self-checking bench for sram_uart_fifo; covers both builds of SRAM_UART_IRQ_EN.
module tb_sram_uart_fifo;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;

  logic        clka = 1'b0;
  logic        rstn;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta;
  logic        ena;
  logic [7:0]  wea;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        irq;

  int errors = 0;
  int checks = 0;

  sram_uart_fifo #(
    .BASE_ADDR(64'h6000_0000),
    .TX_DEPTH (TX_DEPTH),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .clka    (clka),
    .rstn    (rstn),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .ena     (ena),
    .wea     (wea),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .irq     (irq)
  );

  always #5 clka = ~clka;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-cycle bus write to one register lane; returns 1 time unit after the edge.
  task automatic bus_write(input logic [2:0] off, input logic [7:0] val);
    addra = 64'h6000_0000 | 64'(off);
    dina  = 64'(val) << (8 * off);
    wea   = 8'h01 << off;
    ena   = 1'b1;
    @(posedge clka); #1;
    ena = 1'b0;
    wea = 8'h00;
  endtask

  task automatic bus_read(input logic [2:0] off);
    addra = 64'h6000_0000 | 64'(off);
    wea   = 8'h00;
    ena   = 1'b1;
    @(posedge clka); #1;
    ena = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] val);
    rx_data  = val;
    rx_ready = 1'b1;
    @(posedge clka); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    checks++; if (douta !== 64'h0) begin errors++; $display("FAIL reset_douta: got %h expected %h", douta, 64'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rstn = 1'b1;
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h60) begin errors++; $display("FAIL reset_lsr: got %h expected 60", douta[47:40]); end
    checks++; if (douta[15:0] !== 16'h0000) begin errors++; $display("FAIL reset_lanes01: got %h expected 0000", douta[15:0]); end
    checks++; if (douta[39:16] !== 24'h0 || douta[63:48] !== 16'h0) begin
      errors++; $display("FAIL unused_lanes: got %h expected zero outside lanes 0,1,5", douta);
    end
  endtask

  task automatic test_tx_seq;
    tx_ready = 1'b1;
    bus_write(3'd0, 8'h41);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_latency: got tx_valid=%b expected 0", tx_valid); end
    bus_write(3'd0, 8'h42);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_seq0: got %b/%h expected 1/41", tx_valid, tx_data); end
    bus_write(3'd0, 8'h43);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL tx_seq1: got %b/%h expected 1/42", tx_valid, tx_data); end
    @(posedge clka); #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h43) begin errors++; $display("FAIL tx_seq2: got %b/%h expected 1/43", tx_valid, tx_data); end
    @(posedge clka); #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got tx_valid=%b expected 0", tx_valid); end
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h60) begin errors++; $display("FAIL tx_lsr_idle: got %h expected 60", douta[47:40]); end
  endtask

  task automatic test_tx_overflow;
    int n;
    tx_ready = 1'b0;
    for (int i = 0; i < TX_DEPTH + 2; i++) bus_write(3'd0, 8'h10 + 8'(i));
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin errors++; $display("FAIL tx_hold: got %b/%h expected 1/10", tx_valid, tx_data); end
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h00) begin errors++; $display("FAIL tx_lsr_busy: got %h expected 00", douta[47:40]); end
    tx_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (tx_valid) begin
        checks++;
        if (tx_data !== 8'h10 + 8'(n)) begin errors++; $display("FAIL tx_drain_byte%0d: got %h expected %h", n, tx_data, 8'h10 + 8'(n)); end
        n++;
      end
      @(posedge clka); #1;
    end
    checks++; if (n != TX_DEPTH + 1) begin errors++; $display("FAIL tx_drain_count: got %0d expected %0d", n, TX_DEPTH + 1); end
  endtask

  task automatic test_rx_overrun;
    for (int i = 0; i < RX_DEPTH + 1; i++) rx_push(8'(i));
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h63) begin errors++; $display("FAIL rx_lsr_oe: got %h expected 63", douta[47:40]); end
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h61) begin errors++; $display("FAIL rx_lsr_oe_clr: got %h expected 61", douta[47:40]); end
    for (int i = 0; i < RX_DEPTH; i++) begin
      bus_read(3'd0);
      checks++; if (douta[7:0] !== 8'(i)) begin errors++; $display("FAIL rx_byte%0d: got %h expected %h", i, douta[7:0], 8'(i)); end
    end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h00 || douta[47:40] !== 8'h60) begin
      errors++; $display("FAIL rx_empty_read: got rbr=%h lsr=%h expected 00/60", douta[7:0], douta[47:40]);
    end
  endtask

  task automatic test_rx_same_cycle;
    rx_push(8'hAA);
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    bus_read(3'd0);
    rx_ready = 1'b0;
    checks++; if (douta[7:0] !== 8'hAA) begin errors++; $display("FAIL rx_same_cycle_head: got %h expected AA", douta[7:0]); end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h55) begin errors++; $display("FAIL rx_same_cycle_next: got %h expected 55", douta[7:0]); end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h00 || douta[47:40] !== 8'h60) begin
      errors++; $display("FAIL rx_same_cycle_empty: got rbr=%h lsr=%h expected 00/60", douta[7:0], douta[47:40]);
    end
  endtask

  task automatic test_rx_full_pop;
    for (int i = 0; i < RX_DEPTH; i++) rx_push(8'h80 + 8'(i));
    rx_data  = 8'hEE;
    rx_ready = 1'b1;
    bus_read(3'd0);
    rx_ready = 1'b0;
    checks++; if (douta[7:0] !== 8'h80) begin errors++; $display("FAIL rx_full_pop_head: got %h expected 80", douta[7:0]); end
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h63) begin errors++; $display("FAIL rx_full_pop_oe: got %h expected 63", douta[47:40]); end
    for (int i = 1; i < RX_DEPTH; i++) begin
      bus_read(3'd0);
      checks++; if (douta[7:0] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL rx_full_pop_byte%0d: got %h expected %h", i, douta[7:0], 8'h80 + 8'(i)); end
    end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h00 || douta[47:40] !== 8'h60) begin
      errors++; $display("FAIL rx_full_pop_dropped: got rbr=%h lsr=%h expected 00/60", douta[7:0], douta[47:40]);
    end
  endtask

  task automatic test_irq;
`ifdef SRAM_UART_IRQ_EN
    bus_write(3'd1, 8'h01);
    bus_read(3'd1);
    checks++; if (douta[15:8] !== 8'h01) begin errors++; $display("FAIL ier_read: got %h expected 01", douta[15:8]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
    rx_push(8'h33);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_early: got %b expected 0", irq); end
    @(posedge clka); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b expected 1", irq); end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h33) begin errors++; $display("FAIL irq_rx_byte: got %h expected 33", douta[7:0]); end
    @(posedge clka); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_clear: got %b expected 0", irq); end
    bus_write(3'd1, 8'h02);
    @(posedge clka); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_thre: got %b expected 1", irq); end
    bus_write(3'd1, 8'h00);
    @(posedge clka); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b expected 0", irq); end
`else
    bus_write(3'd1, 8'h03);
    bus_read(3'd1);
    checks++; if (douta[15:8] !== 8'h00) begin errors++; $display("FAIL ier_ignored: got %h expected 00", douta[15:8]); end
    rx_push(8'h33);
    repeat (2) @(posedge clka);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b expected 0", irq); end
    bus_read(3'd0);
    checks++; if (douta[7:0] !== 8'h33) begin errors++; $display("FAIL irq_off_rx_byte: got %h expected 33", douta[7:0]); end
`endif
  endtask

  task automatic test_reset_midflight;
    tx_ready = 1'b0;
    bus_write(3'd0, 8'h77);
    bus_write(3'd0, 8'h78);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL midflight_hold: got %b/%h expected 1/77", tx_valid, tx_data); end
    rstn = 1'b0;
    @(posedge clka); #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL midflight_reset: got %b/%h expected 0/00", tx_valid, tx_data); end
    rstn     = 1'b1;
    tx_ready = 1'b1;
    bus_read(3'd5);
    checks++; if (douta[47:40] !== 8'h60) begin errors++; $display("FAIL midflight_lsr: got %h expected 60", douta[47:40]); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midflight_no_tx: got %b expected 0", tx_valid); end
  endtask

  initial begin
    rstn     = 1'b0;
    addra    = 64'h0;
    dina     = 64'h0;
    ena      = 1'b0;
    wea      = 8'h00;
    tx_ready = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;

    test_reset;
    test_tx_seq;
    test_tx_overflow;
    test_rx_overrun;
    test_rx_same_cycle;
    test_rx_full_pop;
    test_irq;
    test_reset_midflight;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
